shared_resource_arbiter_n: RTL and testbench
============================================

Name: shared_resource_arbiter_n

Overview:
Parametrised N-channel front-end for a single shared fixed-latency resource.
- Each pipeline channel has its own request FIFO.
- A round-robin or fixed-priority arbiter issues one request per cycle to the resource.
- A tag pipeline tracks which channel owns each in-flight operation and routes each result back to that channel.
- Supports per-channel flush, which kills queued and in-flight work, and flags protocol errors.
- Sits between NUM_CH pipeline instances and one shared_resource instance in the wrapper.

Parameters:
- NUM_CH, 2: number of requesting pipelines (2..8).
- DATA_W, 32: request/result data width.
- BUF_DEPTH, 2: per-channel FIFO depth (power of two, ≥2).
- RES_LAT, 2: fixed shared-resource latency in cycles (≥1).
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel request strobe.
- req_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_CH  FIFO i not full; a transfer occurs when valid&ready; stall_i = ~req_ready[i].
- flush  in  NUM_CH  per-channel kill pulse.
- res_issue_valid  out  1  operation presented to the resource.
- res_issue_data  out  DATA_W  operand to the resource.
- grant  out  NUM_CH  one-hot channel issued this cycle (0 if none).
- res_ret_valid  in  1  resource result strobe, exactly RES_LAT cycles after issue.
- res_ret_data  in  DATA_W  resource result.
- rsp_valid  out  NUM_CH  one-hot registered response to the owning channel.
- rsp_data  out  DATA_W  registered result, shared bus.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFOs empty; rr_ptr=0; tag pipeline invalid.
  - rsp_valid=0, rsp_data=0, err=0, res_issue_valid=0, grant=0, req_ready=all ones.
  - A reset asserted mid-operation discards everything; no responses are produced for pre-reset work.
- FIFO:
  - Registered; no bypass.
  - An entry written in cycle t is eligible for issue at t+1.
  - Simultaneous push and pop when full is not allowed, because req_ready is based only on the count.
  - Depth counter covers 0..BUF_DEPTH; pointers wrap modulo BUF_DEPTH.
- Arbitration (combinational, each cycle):
  - Eligible channels: FIFO non-empty and flush[i]=0.
  - Round-robin: scan starting at rr_ptr; the first eligible channel g wins; rr_ptr <= (g+1) mod NUM_CH. rr_ptr is unchanged if nothing is granted.
  - Fixed priority: the lowest eligible index wins; rr_ptr is unused.
  - Winner: grant[g]=1, res_issue_valid=1, res_issue_data=FIFO head of g; FIFO g pops the same cycle.
  - The resource always accepts (no backpressure).
- Tag pipeline:
  - RES_LAT stages of {valid, ch_id[clog2(NUM_CH)]}.
  - Stage 0 is loaded with {res_issue_valid, g}; the pipeline shifts every cycle.
- Return:
  - When the last stage is valid and res_ret_valid=1: next cycle rsp_valid[ch_id]=1 and rsp_data=res_ret_data.
  - Otherwise rsp_valid=0 and rsp_data holds its previous value.
- Latency: push at cycle t → issue at t+1 (earliest) → return at t+1+RES_LAT → rsp at t+2+RES_LAT.
- Flush of channel i in cycle t:
  - FIFO i is cleared; a push to channel i in the same cycle is dropped and req_ready[i] is ignored.
  - Channel i is not granted in cycle t.
  - Every tag stage with ch_id==i is invalidated, including the stage returning at t, so no rsp for i is produced from it.
  - Other channels are unaffected.
  - A killed tag that meets res_ret_valid=1 is not an error.
- err:
  - Set when res_ret_valid=1 while the last tag stage was never issued (neither valid nor killed).
  - Also set when the last stage is a valid (unkilled) tag and res_ret_valid=0.
  - Sticky until reset.
  - Implementation tracks a separate "issued" bit per stage to distinguish killed from empty.

Test Plan:
1. NUM_CH=2, RES_LAT=2. Push 0x11 on ch0 at cycle 0 → cycle 1: grant=01, res_issue_data=0x11. Bench returns 0x22 at cycle 3 → cycle 4: rsp_valid=01, rsp_data=0x22.
2. ARB_MODE=0, both FIFOs hold 2 entries → grant sequence 01,10,01,10. With ARB_MODE=1, same stimulus → 01,01,10,10.
3. ARB_MODE=1, BUF_DEPTH=2, ch0 continuously fed while ch1 pushes 3 words A,B,C → req_ready[1]=0 after B is stored; C is held by the source. Once ch0 drains, ch1 results return in order A,B,C with no loss or duplication.
4. Ch0 has 2 in flight and 1 queued, ch1 has 1 in flight; pulse flush[0] for one cycle → no further rsp_valid[0] for those 3; ch1 rsp arrives on schedule; err stays 0. A new ch0 push then completes in 4 cycles.
5. res_ret_valid pulsed with the tag pipeline empty → err=1 the next cycle and remains 1 until reset=0.
6. Assert reset=0 asynchronously while 2 operations are in flight → outputs clear immediately, req_ready=11. After release, no stale rsp appears and the first grant goes to ch0 (rr_ptr=0).

Source files
------------

// File: rtl/shared_resource_arbiter_n.sv
// shared_resource_arbiter_n
// Front-end that lets NUM_CH pipelines share one fixed-latency resource.
// Each channel queues requests in its own FIFO. An arbiter (round-robin or
// fixed priority) issues at most one request per cycle. A tag pipeline that
// mirrors the resource latency routes each result back to the channel that
// issued it.
//
// Ports:
//   clk_i             clock, all state on the rising edge
//   rst_ni            asynchronous active-low reset
//   req_valid_i       per-channel request strobe
//   req_data_i        per-channel operand, channel i at [i*DATA_W +: DATA_W]
//   req_ready_o       per-channel FIFO not full
//   flush_i           per-channel kill of queued and in-flight work
//   res_issue_valid_o operation presented to the resource this cycle
//   res_issue_data_o  operand presented to the resource
//   grant_o           one-hot channel issued this cycle
//   res_ret_valid_i   resource result strobe, RES_LAT cycles after issue
//   res_ret_data_i    resource result
//   rsp_valid_o       one-hot registered response strobe
//   rsp_data_o        registered response data, shared by all channels
//   err_o             sticky protocol error
module shared_resource_arbiter_n #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2,
  parameter int RES_LAT   = 2,
  parameter int ARB_MODE  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  input  logic [NUM_CH-1:0]        flush_i,
  output logic                     res_issue_valid_o,
  output logic [DATA_W-1:0]        res_issue_data_o,
  output logic [NUM_CH-1:0]        grant_o,
  input  logic                     res_ret_valid_i,
  input  logic [DATA_W-1:0]        res_ret_data_i,
  output logic [NUM_CH-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]        rsp_data_o,
  output logic                     err_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int LAST  = RES_LAT - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  logic [DATA_W-1:0] mem_q    [NUM_CH][BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];

  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] push, eligible;
  logic              gnt_any;
  logic [CH_W-1:0]   gnt_idx;

  // valid: tag still owns a result. issued: something was sent into this
  // slot, even if a flush later killed it, so a return there is legal.
  logic [RES_LAT-1:0] tag_v_q, tag_iss_q, tag_live;
  logic [CH_W-1:0]    tag_ch_q [RES_LAT];

  logic              ret_hit;
  logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;

  // A flushing channel neither accepts a push nor competes for the grant.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req_ready_o[i] = (cnt_q[i] != FULL_CNT);
      push[i]        = req_valid_i[i] & req_ready_o[i] & ~flush_i[i];
      eligible[i]    = (cnt_q[i] != '0) & ~flush_i[i];
    end
  end

  always_comb begin
    logic [CH_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (ARB_MODE == 1) begin
      // Scan downwards so the lowest eligible index is the last one written.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (eligible[k]) begin
          gnt_any = 1'b1;
          gnt_idx = CH_W'(k);
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
        if (!gnt_any && eligible[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      if (gnt_idx == CH_W'(NUM_CH - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = gnt_idx + 1'b1;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      grant_o[i] = gnt_any && (gnt_idx == CH_W'(i));
    end
    res_issue_valid_o = gnt_any;
    res_issue_data_o  = gnt_any ? mem_q[gnt_idx][rd_ptr_q[gnt_idx]] : '0;
  end

  // Storage needs no reset; the count alone decides what is readable.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= req_data_i[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (flush_i[i]) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
          cnt_q[i]    <= '0;
        end else begin
          if (push[i])    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (grant_o[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
          if (push[i] && !grant_o[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
          else if (!push[i] && grant_o[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Kill is applied to the current stage contents, so the tag returning in
  // the flush cycle is suppressed too.
  always_comb begin
    for (int s = 0; s < RES_LAT; s++) begin
      tag_live[s] = tag_v_q[s] & ~flush_i[tag_ch_q[s]];
    end
    ret_hit    = tag_live[LAST] & res_ret_valid_i;
    rsp_data_d = ret_hit ? res_ret_data_i : rsp_data_q;
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ret_hit && (tag_ch_q[LAST] == CH_W'(i))) rsp_valid_d[i] = 1'b1;
    end
    err_d = err_q
          | (res_ret_valid_i & ~tag_iss_q[LAST])
          | (tag_live[LAST] & ~res_ret_valid_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_v_q   <= '0;
      tag_iss_q <= '0;
      for (int s = 0; s < RES_LAT; s++) tag_ch_q[s] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      tag_v_q[0]   <= gnt_any;
      tag_iss_q[0] <= gnt_any;
      tag_ch_q[0]  <= gnt_idx;
      for (int s = 1; s < RES_LAT; s++) begin
        tag_v_q[s]   <= tag_live[s-1];
        tag_iss_q[s] <= tag_iss_q[s-1];
        tag_ch_q[s]  <= tag_ch_q[s-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_shared_resource_arbiter_n.sv
// Directed bench for shared_resource_arbiter_n. Two instances share the same
// request stimulus: one round-robin, one fixed priority. Each has its own
// resource model returning operand + 0x11 exactly two cycles after issue.
module tb_shared_resource_arbiter_n;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inject;
  logic [1:0]  reqValid;
  logic [63:0] reqData;
  logic [1:0]  flush;

  logic [1:0]  rrReady, rrGrant, rrRspValid;
  logic        rrIssueValid, rrRetValid, rrErr;
  logic [31:0] rrIssueData, rrRetData, rrRspData;

  logic [1:0]  fpReady, fpGrant, fpRspValid;
  logic        fpIssueValid, fpRetValid, fpErr;
  logic [31:0] fpIssueData, fpRetData, fpRspData;

  logic [32:0] rrPipe0, rrPipe1, fpPipe0, fpPipe1;

  int nCompared;
  int nMismatched;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  shared_resource_arbiter_n #(
    .NUM_CH(2), .DATA_W(32), .BUF_DEPTH(2), .RES_LAT(2), .ARB_MODE(0)
  ) dutRr (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_data_i(reqData), .req_ready_o(rrReady),
    .flush_i(flush),
    .res_issue_valid_o(rrIssueValid), .res_issue_data_o(rrIssueData),
    .grant_o(rrGrant),
    .res_ret_valid_i(rrRetValid), .res_ret_data_i(rrRetData),
    .rsp_valid_o(rrRspValid), .rsp_data_o(rrRspData), .err_o(rrErr)
  );

  shared_resource_arbiter_n #(
    .NUM_CH(2), .DATA_W(32), .BUF_DEPTH(2), .RES_LAT(2), .ARB_MODE(1)
  ) dutFp (
    .clk_i(clk), .rst_ni(rstN),
    .req_valid_i(reqValid), .req_data_i(reqData), .req_ready_o(fpReady),
    .flush_i(flush),
    .res_issue_valid_o(fpIssueValid), .res_issue_data_o(fpIssueData),
    .grant_o(fpGrant),
    .res_ret_valid_i(fpRetValid), .res_ret_data_i(fpRetData),
    .rsp_valid_o(fpRspValid), .rsp_data_o(fpRspData), .err_o(fpErr)
  );

  // Resource models: two-stage delay line that adds 0x11 to the operand.
  // They reset with the DUTs, like the real resource in the wrapper.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rrPipe0 <= '0;
      rrPipe1 <= '0;
      fpPipe0 <= '0;
      fpPipe1 <= '0;
    end else begin
      rrPipe0 <= {rrIssueValid, rrIssueData + 32'h11};
      rrPipe1 <= rrPipe0;
      fpPipe0 <= {fpIssueValid, fpIssueData + 32'h11};
      fpPipe1 <= fpPipe0;
    end
  end

  // The inject strobe forces a spurious return into the round-robin DUT.
  assign rrRetValid = rrPipe1[32] | inject;
  assign rrRetData  = rrPipe1[31:0];
  assign fpRetValid = fpPipe1[32];
  assign fpRetData  = fpPipe1[31:0];

  // Drive one cycle of inputs just after the rising edge, then return at the
  // falling edge so outputs have settled for checking.
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [1:0] fl);
    @(posedge clk);
    #1;
    reqValid = v;
    reqData  = {d1, d0};
    flush    = fl;
    inject   = 1'b0;
    @(negedge clk);
  endtask

  // One comparison against a hand-computed expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Short synchronous-release reset used to return both DUTs to a known state.
  task automatic doReset();
    @(posedge clk);
    #1;
    rstN     = 1'b0;
    reqValid = '0;
    flush    = '0;
    inject   = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    rstN = 1'b0; reqValid = '0; reqData = '0; flush = '0; inject = 1'b0;
    nCompared = 0; nMismatched = 0;

    // Reset values
    #12;
    checkOutput("reset rsp_valid", 32'(rrRspValid), 32'h0);
    checkOutput("reset rsp_data", rrRspData, 32'h0);
    checkOutput("reset err", 32'(rrErr), 32'h0);
    checkOutput("reset issue_valid", 32'(rrIssueValid), 32'h0);
    checkOutput("reset grant", 32'(rrGrant), 32'h0);
    checkOutput("reset req_ready", 32'(rrReady), 32'h3);
    checkOutput("reset fp req_ready", 32'(fpReady), 32'h3);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Single ch0 transaction end to end
    applyStimulus(2'b01, 32'h11, 32'h0, 2'b00);
    checkOutput("t1 c0 grant", 32'(rrGrant), 32'h0);
    checkOutput("t1 c0 ready", 32'(rrReady), 32'h3);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t1 c1 grant", 32'(rrGrant), 32'h1);
    checkOutput("t1 c1 issue_valid", 32'(rrIssueValid), 32'h1);
    checkOutput("t1 c1 issue_data", rrIssueData, 32'h11);
    checkOutput("t1 c1 fp grant", 32'(fpGrant), 32'h1);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t1 c2 rsp_valid", 32'(rrRspValid), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t1 c3 rsp_valid", 32'(rrRspValid), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t1 c4 rsp_valid", 32'(rrRspValid), 32'h1);
    checkOutput("t1 c4 rsp_data", rrRspData, 32'h22);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t1 c5 rsp_valid", 32'(rrRspValid), 32'h0);
    checkOutput("t1 c5 rsp_data hold", rrRspData, 32'h22);
    checkOutput("t1 c5 err", 32'(rrErr), 32'h0);

    // Single ch1 transaction; also moves rr_ptr back to 0
    applyStimulus(2'b10, 32'h0, 32'h33, 2'b00);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t1b grant", 32'(rrGrant), 32'h2);
    checkOutput("t1b issue_data", rrIssueData, 32'h33);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t1b rsp_valid", 32'(rrRspValid), 32'h2);
    checkOutput("t1b rsp_data", rrRspData, 32'h44);

    // Round-robin vs fixed priority with two entries per channel
    applyStimulus(2'b11, 32'h100, 32'h200, 2'b00);
    checkOutput("t2 a rr grant", 32'(rrGrant), 32'h0);
    applyStimulus(2'b11, 32'h101, 32'h201, 2'b00);
    checkOutput("t2 b rr grant", 32'(rrGrant), 32'h1);
    checkOutput("t2 b rr data", rrIssueData, 32'h100);
    checkOutput("t2 b fp grant", 32'(fpGrant), 32'h1);
    checkOutput("t2 b fp data", fpIssueData, 32'h100);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t2 c rr grant", 32'(rrGrant), 32'h2);
    checkOutput("t2 c rr data", rrIssueData, 32'h200);
    checkOutput("t2 c fp grant", 32'(fpGrant), 32'h1);
    checkOutput("t2 c fp data", fpIssueData, 32'h101);
    checkOutput("t2 c rr ready", 32'(rrReady), 32'h1);
    checkOutput("t2 c fp ready", 32'(fpReady), 32'h1);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t2 d rr grant", 32'(rrGrant), 32'h1);
    checkOutput("t2 d rr data", rrIssueData, 32'h101);
    checkOutput("t2 d fp grant", 32'(fpGrant), 32'h2);
    checkOutput("t2 d fp data", fpIssueData, 32'h200);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t2 e rr grant", 32'(rrGrant), 32'h2);
    checkOutput("t2 e fp grant", 32'(fpGrant), 32'h2);
    checkOutput("t2 e rr rsp_valid", 32'(rrRspValid), 32'h1);
    checkOutput("t2 e rr rsp_data", rrRspData, 32'h111);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t2 f rr rsp_valid", 32'(rrRspValid), 32'h2);
    checkOutput("t2 f rr rsp_data", rrRspData, 32'h211);
    checkOutput("t2 f fp rsp_valid", 32'(fpRspValid), 32'h1);
    checkOutput("t2 f fp rsp_data", fpRspData, 32'h112);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t2 g rr rsp_valid", 32'(rrRspValid), 32'h1);
    checkOutput("t2 g fp rsp_valid", 32'(fpRspValid), 32'h2);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t2 h rr rsp_data", rrRspData, 32'h212);
    checkOutput("t2 h fp rsp_data", fpRspData, 32'h212);

    // Fixed priority backpressure: ch0 fed every cycle, ch1 sends A,B,C
    applyStimulus(2'b11, 32'h300, 32'hA, 2'b00);
    checkOutput("t3 q0 fp grant", 32'(fpGrant), 32'h0);
    checkOutput("t3 q0 fp ready", 32'(fpReady), 32'h3);
    applyStimulus(2'b11, 32'h301, 32'hB, 2'b00);
    checkOutput("t3 q1 fp grant", 32'(fpGrant), 32'h1);
    checkOutput("t3 q1 fp data", fpIssueData, 32'h300);
    applyStimulus(2'b11, 32'h302, 32'hC, 2'b00);
    checkOutput("t3 q2 fp ready", 32'(fpReady), 32'h1);
    checkOutput("t3 q2 fp data", fpIssueData, 32'h301);
    applyStimulus(2'b11, 32'h303, 32'hC, 2'b00);
    checkOutput("t3 q3 fp ready", 32'(fpReady), 32'h1);
    applyStimulus(2'b10, 32'h0, 32'hC, 2'b00);
    checkOutput("t3 q4 fp grant", 32'(fpGrant), 32'h1);
    checkOutput("t3 q4 fp data", fpIssueData, 32'h303);
    applyStimulus(2'b10, 32'h0, 32'hC, 2'b00);
    checkOutput("t3 q5 fp grant", 32'(fpGrant), 32'h2);
    checkOutput("t3 q5 fp data", fpIssueData, 32'hA);
    checkOutput("t3 q5 fp ready", 32'(fpReady), 32'h1);
    applyStimulus(2'b10, 32'h0, 32'hC, 2'b00);
    checkOutput("t3 q6 fp ready", 32'(fpReady), 32'h3);
    checkOutput("t3 q6 fp data", fpIssueData, 32'hB);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t3 q7 fp grant", 32'(fpGrant), 32'h2);
    checkOutput("t3 q7 fp data", fpIssueData, 32'hC);
    checkOutput("t3 q7 fp rsp_valid", 32'(fpRspValid), 32'h1);
    checkOutput("t3 q7 fp rsp_data", fpRspData, 32'h314);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t3 q8 fp rsp_valid", 32'(fpRspValid), 32'h2);
    checkOutput("t3 q8 fp rsp_data", fpRspData, 32'h1B);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t3 q9 fp rsp_valid", 32'(fpRspValid), 32'h2);
    checkOutput("t3 q9 fp rsp_data", fpRspData, 32'h1C);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t3 q10 fp rsp_valid", 32'(fpRspValid), 32'h2);
    checkOutput("t3 q10 fp rsp_data", fpRspData, 32'h1D);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t3 q11 fp rsp_valid", 32'(fpRspValid), 32'h0);
    checkOutput("t3 q11 fp err", 32'(fpErr), 32'h0);

    doReset();

    // Flush of ch0 with two ch0 tags in flight and one queued
    applyStimulus(2'b01, 32'h400, 32'h0, 2'b00);
    checkOutput("t4 s0 grant", 32'(rrGrant), 32'h0);
    applyStimulus(2'b01, 32'h401, 32'h0, 2'b00);
    checkOutput("t4 s1 data", rrIssueData, 32'h400);
    applyStimulus(2'b11, 32'h402, 32'h500, 2'b00);
    checkOutput("t4 s2 grant", 32'(rrGrant), 32'h1);
    checkOutput("t4 s2 data", rrIssueData, 32'h401);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b01);
    checkOutput("t4 s3 grant", 32'(rrGrant), 32'h2);
    checkOutput("t4 s3 data", rrIssueData, 32'h500);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t4 s4 rsp_valid", 32'(rrRspValid), 32'h0);
    checkOutput("t4 s4 grant", 32'(rrGrant), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t4 s5 rsp_valid", 32'(rrRspValid), 32'h0);
    applyStimulus(2'b01, 32'h600, 32'h0, 2'b00);
    checkOutput("t4 s6 rsp_valid", 32'(rrRspValid), 32'h2);
    checkOutput("t4 s6 rsp_data", rrRspData, 32'h511);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t4 s7 grant", 32'(rrGrant), 32'h1);
    checkOutput("t4 s7 data", rrIssueData, 32'h600);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t4 s8 rsp_valid", 32'(rrRspValid), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t4 s9 rsp_valid", 32'(rrRspValid), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t4 s10 rsp_valid", 32'(rrRspValid), 32'h1);
    checkOutput("t4 s10 rsp_data", rrRspData, 32'h611);
    checkOutput("t4 s10 err", 32'(rrErr), 32'h0);

    // Spurious return with an empty tag pipeline
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    inject = 1'b1;
    checkOutput("t5 u0 err", 32'(rrErr), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t5 u1 err", 32'(rrErr), 32'h1);
    checkOutput("t5 u1 rsp_valid", 32'(rrRspValid), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t5 u3 err sticky", 32'(rrErr), 32'h1);

    // Asynchronous reset with work in flight
    applyStimulus(2'b11, 32'h700, 32'h800, 2'b00);
    checkOutput("t6 v0 err", 32'(rrErr), 32'h1);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t6 v1 grant", 32'(rrGrant), 32'h2);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t6 v2 grant", 32'(rrGrant), 32'h1);
    @(posedge clk);
    #1;
    reqValid = 2'b01;
    reqData  = {32'h0, 32'h900};
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6 async rsp_valid", 32'(rrRspValid), 32'h0);
    checkOutput("t6 async rsp_data", rrRspData, 32'h0);
    checkOutput("t6 async err", 32'(rrErr), 32'h0);
    checkOutput("t6 async issue_valid", 32'(rrIssueValid), 32'h0);
    checkOutput("t6 async grant", 32'(rrGrant), 32'h0);
    checkOutput("t6 async ready", 32'(rrReady), 32'h3);
    reqValid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(2'b11, 32'hA00, 32'hB00, 2'b00);
    checkOutput("t6 w0 rsp_valid", 32'(rrRspValid), 32'h0);
    checkOutput("t6 w0 grant", 32'(rrGrant), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t6 w1 grant", 32'(rrGrant), 32'h1);
    checkOutput("t6 w1 data", rrIssueData, 32'hA00);
    checkOutput("t6 w1 rsp_valid", 32'(rrRspValid), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t6 w2 grant", 32'(rrGrant), 32'h2);
    checkOutput("t6 w2 rsp_valid", 32'(rrRspValid), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t6 w3 rsp_valid", 32'(rrRspValid), 32'h0);
    checkOutput("t6 w3 err", 32'(rrErr), 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0, 2'b00);
    checkOutput("t6 w4 rsp_valid", 32'(rrRspValid), 32'h1);
    checkOutput("t6 w4 rsp_data", rrRspData, 32'hA11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
